// File: rtl/case_match_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : case_match_encoder
// Brief    : Walks a captured case-item match vector and emits one entry per
//            set bit (lowest first), or a single default entry when none match.
// Revision : 1.0
// ============================================================================
module case_match_encoder #(
    parameter int N    = 8,
    parameter int IDXW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_vec,
    input  logic            first_only,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] out_idx,
    output logic            out_default,
    output logic            out_last,
    output logic [IDXW:0]   out_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_pend, w_pend_nxt;
    logic            r_mode, w_mode_nxt;
    logic            r_rdy, w_rdy_nxt;
    logic            r_valid, w_valid_nxt;
    logic [IDXW-1:0] r_idx, w_idx_nxt;
    logic            r_dflt, w_dflt_nxt;
    logic            r_last, w_last_nxt;
    logic [IDXW:0]   r_cnt, w_cnt_nxt;

    logic            w_accept;
    logic            w_hs;
    logic [N-1:0]    w_rem;

    // Bit 0 has the highest priority, so scan downward and keep the last hit.
    function automatic logic [IDXW-1:0] lowest(input logic [N-1:0] v);
        lowest = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) lowest = i[IDXW-1:0];
        end
    endfunction

    function automatic logic at_most_one(input logic [N-1:0] v);
        at_most_one = ((v & (v - 1'b1)) == '0);
    endfunction

    assign w_accept = in_valid && r_rdy && (r_state == IDLE);
    assign w_hs     = r_valid && out_ready;
    // pend still holds the presented bit; clearing the lowest set bit drops it.
    assign w_rem    = r_pend & (r_pend - 1'b1);

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_mode_nxt  = r_mode;
        w_rdy_nxt   = r_rdy;
        w_valid_nxt = r_valid;
        w_idx_nxt   = r_idx;
        w_dflt_nxt  = r_dflt;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_rdy_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt = EMIT;
                    w_pend_nxt  = in_vec;
                    w_mode_nxt  = first_only;
                    w_rdy_nxt   = 1'b0;
                    w_valid_nxt = 1'b1;
                    w_idx_nxt   = lowest(in_vec);
                    w_dflt_nxt  = (in_vec == '0);
                    w_last_nxt  = first_only || at_most_one(in_vec);
                    w_cnt_nxt   = {{IDXW{1'b0}}, 1'b1};
                end
            end
            EMIT: begin
                if (w_hs) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                        w_pend_nxt  = '0;
                        w_mode_nxt  = 1'b0;
                        w_rdy_nxt   = 1'b1;
                        w_valid_nxt = 1'b0;
                        w_idx_nxt   = '0;
                        w_dflt_nxt  = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_pend_nxt  = w_rem;
                        w_idx_nxt   = lowest(w_rem);
                        w_last_nxt  = r_mode || at_most_one(w_rem);
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_mode  <= 1'b0;
            r_rdy   <= 1'b0;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_dflt  <= 1'b0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_mode  <= w_mode_nxt;
            r_rdy   <= w_rdy_nxt;
            r_valid <= w_valid_nxt;
            r_idx   <= w_idx_nxt;
            r_dflt  <= w_dflt_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            assert (!$isunknown(in_vec));
        end
    end
`endif

    // Ready is registered so it rises on the first edge after reset release.
    assign in_ready    = r_rdy;
    assign out_valid   = r_valid;
    assign out_idx     = r_idx;
    assign out_default = r_dflt;
    assign out_last    = r_last;
    assign out_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_case_match_encoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_case_match_encoder
// Brief    : Self-checking bench for case_match_encoder against an entry-list model.
// Revision : 1.0
// ============================================================================
module tb_case_match_encoder;

    localparam int N    = 8;
    localparam int IDXW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_vec;
    logic            first_only;
    logic            out_valid;
    logic            out_ready;
    logic [IDXW-1:0] out_idx;
    logic            out_default;
    logic            out_last;
    logic [IDXW:0]   out_cnt;

    case_match_encoder #(.N(N), .IDXW(IDXW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_vec      (in_vec),
        .first_only  (first_only),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .out_default (out_default),
        .out_last    (out_last),
        .out_cnt     (out_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit dflt;
        bit last;
        int cnt;
    } ent_t;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected entry list: every set bit in ascending order (or only the first).
    function automatic void build(input logic [N-1:0] v, input bit m);
        int c;
        exp_q.delete();
        if (v == '0) begin
            exp_q.push_back('{0, 1'b1, 1'b1, 1});
        end else begin
            c = 0;
            for (int i = 0; i < N; i++) begin
                if (v[i]) begin
                    c++;
                    exp_q.push_back('{i, 1'b0, 1'b0, c});
                    if (m) break;
                end
            end
            exp_q[exp_q.size() - 1].last = 1'b1;
        end
    endfunction

    // Entered and left at a falling edge with the DUT idle.
    // rmode: 0 = out_ready always high, 1 = random, 2 = low for the first 3 cycles.
    task automatic send(input logic [N-1:0] v, input bit m, input int rmode);
        ent_t e;
        int   cyc;
        check("ready_before_accept", in_ready, 1);
        build(v, m);
        in_valid   = 1'b1;
        in_vec     = v;
        first_only = m;
        out_ready  = 1'b0;
        for (cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
            in_valid   = $urandom_range(0, 1);
            in_vec     = N'($urandom);
            first_only = $urandom_range(0, 1);
            e = exp_q[0];
            check("valid", out_valid, 1);
            check("in_ready_emit", in_ready, 0);
            check("idx", out_idx, e.idx);
            check("default", out_default, e.dflt);
            check("last", out_last, e.last);
            check("cnt", out_cnt, e.cnt);
            case (rmode)
                0:       out_ready = 1'b1;
                2:       out_ready = (cyc >= 3);
                default: out_ready = $urandom_range(0, 1);
            endcase
            if (out_ready) void'(exp_q.pop_front());
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("drain_timeout", exp_q.size(), 0);
        check("valid_after_last", out_valid, 0);
        check("ready_after_last", in_ready, 1);
        check("cnt_after_last", out_cnt, 0);
    endtask

    initial begin
        logic [N-1:0] v;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_vec     = '0;
        first_only = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_idx", out_idx, 0);
        check("rst_default", out_default, 0);
        check("rst_last", out_last, 0);
        check("rst_cnt", out_cnt, 0);
        rst = 1'b0;
        #1 check("ready_before_edge", in_ready, 0);
        @(negedge clk);
        check("ready_after_release", in_ready, 1);

        send(8'b0100_1010, 1'b0, 0);
        send(8'b0100_1010, 1'b1, 0);
        send(8'h00, 1'b0, 0);
        send(8'h81, 1'b0, 2);
        send(8'h80, 1'b0, 0);

        // Reset after the first handshake of a full vector.
        in_vec     = 8'hFF;
        first_only = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("ff_idx0", out_idx, 0);
        check("ff_cnt1", out_cnt, 1);
        @(negedge clk);
        check("ff_idx1", out_idx, 1);
        check("ff_cnt2", out_cnt, 2);
        #2 rst = 1'b1;
        #1 check("rst_async_valid", out_valid, 0);
        check("rst_async_ready", in_ready, 0);
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_mid_ready_low", in_ready, 0);
        @(negedge clk);
        check("rst_mid_ready_high", in_ready, 1);
        check("rst_mid_no_entry", out_valid, 0);
        send(8'h04, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = N'(1) << $urandom_range(0, N - 1);
                default: v = N'($urandom);
            endcase
            send(v, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
